ctrl_update_queue: RTL and testbench

CTRL_UPDATE_QUEUE -- requirements
Module: ctrl_update_queue

---
 rtl/ctrl_update_queue_if.sv | 31 +++
 rtl/ctrl_update_queue.sv | 122 ++++++++++++
 tb/tb_ctrl_update_queue.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_update_queue_if.sv
// Control-result and predictor-update bus between writeback, the update queue and the predictor.
interface ctrl_update_queue_if #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CTI_W = 4
);
    logic             ctrl_valid_i;
    logic             ctrl_mispredict_i;
    logic             ctrl_conditional_i;
    logic [PC_W-1:0]  ctrl_target_i;
    logic             ctrl_dir_i;
    logic [CTI_W-1:0] ctrl_cti_idx_i;

    logic             upd_valid_o;
    logic             upd_ready_i;
    logic [CTI_W-1:0] upd_cti_idx_o;
    logic [PC_W-1:0]  upd_target_o;
    logic             upd_dir_o;
    logic             upd_conditional_o;

    modport master (
        output ctrl_valid_i, ctrl_mispredict_i, ctrl_conditional_i,
               ctrl_target_i, ctrl_dir_i, ctrl_cti_idx_i, upd_ready_i,
        input  upd_valid_o, upd_cti_idx_o, upd_target_o, upd_dir_o, upd_conditional_o
    );

    modport slave (
        input  ctrl_valid_i, ctrl_mispredict_i, ctrl_conditional_i,
               ctrl_target_i, ctrl_dir_i, ctrl_cti_idx_i, upd_ready_i,
        output upd_valid_o, upd_cti_idx_o, upd_target_o, upd_dir_o, upd_conditional_o
    );
endinterface

// File: rtl/ctrl_update_queue.sv
// Queues verified control results for predictor update and issues fetch redirects on mispredicts.
// Optional sticky drop detection is enabled by defining CTRL_UPD_OVERFLOW_CHK_EN.
module ctrl_update_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CTI_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    ctrl_update_queue_if.slave       bus,
    input  logic                     recover_done_i,
    output logic                     redirect_valid_o,
    output logic [PC_W-1:0]          redirect_pc_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     overflow_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ctrl_update_queue: DEPTH must be a power of two >= 2");
    end

    typedef struct packed {
        logic [CTI_W-1:0] ctiIdx;
        logic [PC_W-1:0]  target;
        logic             dir;
        logic             conditional;
    } entry_t;

    typedef enum logic {RUN = 1'b0, RECOVER = 1'b1} state_t;

    entry_t        mem [DEPTH];
    entry_t        headEntry;
    logic [AW-1:0] headPtr;
    logic [AW-1:0] tailPtr;
    logic [CW-1:0] countQ;
    state_t        state;
    logic          isFull;
    logic          updValid;
    logic          doEnq;
    logic          doDeq;

    assign isFull   = (countQ == CW'(DEPTH));
    assign updValid = (countQ != '0);
    assign doDeq    = updValid && bus.upd_ready_i;
    // A full queue still accepts when the head leaves in the same cycle.
    assign doEnq    = (state == RUN) && bus.ctrl_valid_i && (!isFull || doDeq);

    assign headEntry             = mem[headPtr];
    assign bus.upd_valid_o       = updValid;
    assign bus.upd_cti_idx_o     = headEntry.ctiIdx;
    assign bus.upd_target_o      = headEntry.target;
    assign bus.upd_dir_o         = headEntry.dir;
    assign bus.upd_conditional_o = headEntry.conditional;
    assign count_o               = countQ;
    assign full_o                = isFull;

    // Storage array carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (doEnq) begin
            mem[tailPtr] <= '{ctiIdx:      bus.ctrl_cti_idx_i,
                               target:      bus.ctrl_target_i,
                               dir:         bus.ctrl_dir_i,
                               conditional: bus.ctrl_conditional_i};
        end
    end

    // Pointers, occupancy, recovery state and redirect pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            headPtr          <= '0;
            tailPtr          <= '0;
            countQ           <= '0;
            state            <= RUN;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
        end else begin
            redirect_valid_o <= 1'b0;
            if (doEnq) tailPtr <= tailPtr + AW'(1);
            if (doDeq) headPtr <= headPtr + AW'(1);
            case ({doEnq, doDeq})
                2'b10:   countQ <= countQ + CW'(1);
                2'b01:   countQ <= countQ - CW'(1);
                default: countQ <= countQ;
            endcase
            case (state)
                RUN: begin
                    // Redirect fires even when the mispredicted entry itself is dropped.
                    if (bus.ctrl_valid_i && bus.ctrl_mispredict_i) begin
                        redirect_valid_o <= 1'b1;
                        redirect_pc_o    <= bus.ctrl_target_i;
                        state            <= RECOVER;
                    end
                end
                RECOVER: begin
                    if (recover_done_i) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef CTRL_UPD_OVERFLOW_CHK_EN
    logic dropEvt;
    logic overflowQ;

    assign dropEvt = (state == RUN) && bus.ctrl_valid_i && isFull && !doDeq;

    // Sticky until reset.
    always_ff @(posedge clk) begin
        if (reset)        overflowQ <= 1'b0;
        else if (dropEvt) overflowQ <= 1'b1;
    end

    assign overflow_o = overflowQ;
`else
    assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_update_queue.sv
// Directed self-checking bench for ctrl_update_queue (DEPTH=8, PC_W=32, CTI_W=4).
module tb_ctrl_update_queue;
    logic        clk;
    logic        reset;
    logic        recover_done;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [3:0]  count;
    logic        full;
    logic        overflow;
    int          total;
    int          bad;

`ifdef CTRL_UPD_OVERFLOW_CHK_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    ctrl_update_queue_if #(.PC_W(32), .CTI_W(4)) bus ();

    ctrl_update_queue #(.DEPTH(8), .PC_W(32), .CTI_W(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus),
        .recover_done_i   (recover_done),
        .redirect_valid_o (redirect_valid),
        .redirect_pc_o    (redirect_pc),
        .count_o          (count),
        .full_o           (full),
        .overflow_o       (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic mis, input logic [3:0] cti,
                         input logic [31:0] tgt, input logic dir, input logic cond);
        bus.ctrl_valid_i       = v;
        bus.ctrl_mispredict_i  = mis;
        bus.ctrl_cti_idx_i     = cti;
        bus.ctrl_target_i      = tgt;
        bus.ctrl_dir_i         = dir;
        bus.ctrl_conditional_i = cond;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
        total++; if (bus.upd_valid_o !== 1'b0) begin bad++; $display("FAIL reset_upd_valid got=%b want=0", bus.upd_valid_o); end
        total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL reset_redirect_valid got=%b want=0", redirect_valid); end
        total++; if (redirect_pc !== 32'h0) begin bad++; $display("FAIL reset_redirect_pc got=%h want=0", redirect_pc); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
        reset = 1'b0;
    endtask

    task automatic test_basic_fifo();
        bus.upd_ready_i = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b0, 4'(i), 32'h100 * i, i[0], 1'b1);
            if (i == 1) begin
                total++; if (bus.upd_valid_o !== 1'b0) begin bad++; $display("FAIL basic_no_bypass got=%b want=0", bus.upd_valid_o); end
            end
            tick();
            if (i == 1) begin
                total++; if (bus.upd_valid_o !== 1'b1) begin bad++; $display("FAIL basic_latency got=%b want=1", bus.upd_valid_o); end
            end
        end
        idle();
        total++; if (count !== 4'd3) begin bad++; $display("FAIL basic_count3 got=%0d want=3", count); end
        total++; if (bus.upd_cti_idx_o !== 4'd1) begin bad++; $display("FAIL basic_head_cti got=%0d want=1", bus.upd_cti_idx_o); end
        total++; if (bus.upd_conditional_o !== 1'b1) begin bad++; $display("FAIL basic_head_cond got=%b want=1", bus.upd_conditional_o); end
        bus.upd_ready_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            total++; if (bus.upd_cti_idx_o !== 4'(i)) begin bad++; $display("FAIL basic_drain_cti got=%0d want=%0d", bus.upd_cti_idx_o, i); end
            total++; if (bus.upd_target_o !== 32'h100 * i) begin bad++; $display("FAIL basic_drain_target got=%h want=%h", bus.upd_target_o, 32'h100 * i); end
            total++; if (bus.upd_dir_o !== i[0]) begin bad++; $display("FAIL basic_drain_dir got=%b want=%b", bus.upd_dir_o, i[0]); end
            tick();
        end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL basic_count0 got=%0d want=0", count); end
        total++; if (bus.upd_valid_o !== 1'b0) begin bad++; $display("FAIL basic_empty_valid got=%b want=0", bus.upd_valid_o); end
        bus.upd_ready_i = 1'b0;
    endtask

    task automatic test_overflow();
        bus.upd_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 4'(i), 32'h1000 + i, 1'b0, 1'b0);
            tick();
        end
        idle();
        total++; if (count !== 4'd8) begin bad++; $display("FAIL ovf_count8 got=%0d want=8", count); end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL ovf_full got=%b want=1", full); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_before_drop got=%b want=0", overflow); end
        // Ninth result is a mispredict: dropped, but the redirect still fires.
        drive(1'b1, 1'b1, 4'd15, 32'h0000_ABC0, 1'b1, 1'b1);
        tick();
        idle();
        total++; if (count !== 4'd8) begin bad++; $display("FAIL ovf_count_after_drop got=%0d want=8", count); end
        total++; if (bus.upd_cti_idx_o !== 4'd0) begin bad++; $display("FAIL ovf_head got=%0d want=0", bus.upd_cti_idx_o); end
        total++; if (overflow !== OVF_EXP) begin bad++; $display("FAIL ovf_flag got=%b want=%b", overflow, OVF_EXP); end
        total++; if (redirect_valid !== 1'b1) begin bad++; $display("FAIL ovf_drop_redirect got=%b want=1", redirect_valid); end
        total++; if (redirect_pc !== 32'h0000_ABC0) begin bad++; $display("FAIL ovf_drop_pc got=%h want=0000abc0", redirect_pc); end
        recover_done = 1'b1;
        tick();
        recover_done = 1'b0;
        total++; if (overflow !== OVF_EXP) begin bad++; $display("FAIL ovf_sticky got=%b want=%b", overflow, OVF_EXP); end
    endtask

    task automatic test_full_passthrough();
        int expList[8] = '{1, 2, 3, 4, 5, 6, 7, 9};
        bus.upd_ready_i = 1'b1;
        drive(1'b1, 1'b0, 4'd9, 32'h0000_9999, 1'b1, 1'b0);
        tick();
        idle();
        total++; if (count !== 4'd8) begin bad++; $display("FAIL pass_count got=%0d want=8", count); end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL pass_full got=%b want=1", full); end
        for (int k = 0; k < 8; k++) begin
            total++; if (bus.upd_cti_idx_o !== 4'(expList[k])) begin bad++; $display("FAIL pass_order[%0d] got=%0d want=%0d", k, bus.upd_cti_idx_o, expList[k]); end
            tick();
        end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL pass_drained got=%0d want=0", count); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL pass_not_full got=%b want=0", full); end
        bus.upd_ready_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        bus.upd_ready_i = 1'b0;
        drive(1'b1, 1'b0, 4'd4, 32'h0000_0444, 1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b0, 4'd5, 32'h0000_0555, 1'b1, 1'b1);
        bus.upd_ready_i = 1'b1;
        tick();
        idle();
        total++; if (count !== 4'd1) begin bad++; $display("FAIL b2b_count got=%0d want=1", count); end
        total++; if (bus.upd_cti_idx_o !== 4'd5) begin bad++; $display("FAIL b2b_head got=%0d want=5", bus.upd_cti_idx_o); end
        total++; if (bus.upd_target_o !== 32'h0000_0555) begin bad++; $display("FAIL b2b_target got=%h want=00000555", bus.upd_target_o); end
        tick();
        total++; if (count !== 4'd0) begin bad++; $display("FAIL b2b_drained got=%0d want=0", count); end
        bus.upd_ready_i = 1'b0;
    endtask

    task automatic test_mispredict();
        bus.upd_ready_i = 1'b0;
        drive(1'b0, 1'b1, 4'd3, 32'h0000_7777, 1'b1, 1'b1);
        tick();
        total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL mis_no_valid_redirect got=%b want=0", redirect_valid); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL mis_no_valid_count got=%0d want=0", count); end
        drive(1'b1, 1'b1, 4'd6, 32'h0000_4000, 1'b1, 1'b1);
        tick();
        total++; if (redirect_valid !== 1'b1) begin bad++; $display("FAIL mis_redirect_valid got=%b want=1", redirect_valid); end
        total++; if (redirect_pc !== 32'h0000_4000) begin bad++; $display("FAIL mis_redirect_pc got=%h want=00004000", redirect_pc); end
        total++; if (count !== 4'd1) begin bad++; $display("FAIL mis_enqueued got=%0d want=1", count); end
        // In RECOVER: ignored result while the head keeps draining.
        drive(1'b1, 1'b0, 4'd7, 32'h0000_7000, 1'b0, 1'b0);
        bus.upd_ready_i = 1'b1;
        tick();
        total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL mis_pulse_width got=%b want=0", redirect_valid); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL mis_recover_drain got=%0d want=0", count); end
        bus.upd_ready_i = 1'b0;
        drive(1'b1, 1'b1, 4'd8, 32'h0000_8000, 1'b0, 1'b1);
        tick();
        total++; if (count !== 4'd0) begin bad++; $display("FAIL mis_ignored2 got=%0d want=0", count); end
        total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL mis_no_second_redirect got=%b want=0", redirect_valid); end
        total++; if (redirect_pc !== 32'h0000_4000) begin bad++; $display("FAIL mis_pc_hold got=%h want=00004000", redirect_pc); end
        recover_done = 1'b1;
        drive(1'b1, 1'b1, 4'd9, 32'h0000_9000, 1'b0, 1'b1);
        tick();
        recover_done = 1'b0;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL mis_done_cycle_ignored got=%0d want=0", count); end
        total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL mis_done_cycle_redirect got=%b want=0", redirect_valid); end
        drive(1'b1, 1'b0, 4'd10, 32'h0000_A000, 1'b1, 1'b0);
        tick();
        idle();
        total++; if (count !== 4'd1) begin bad++; $display("FAIL mis_after_recover got=%0d want=1", count); end
        total++; if (bus.upd_cti_idx_o !== 4'd10) begin bad++; $display("FAIL mis_after_recover_head got=%0d want=10", bus.upd_cti_idx_o); end
        bus.upd_ready_i = 1'b1;
        tick();
        bus.upd_ready_i = 1'b0;
    endtask

    task automatic test_reset_in_recover();
        bus.upd_ready_i = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, (i == 5), 4'(i), 32'h0000_5000, 1'b0, 1'b1);
            tick();
        end
        idle();
        total++; if (count !== 4'd5) begin bad++; $display("FAIL rr_count5 got=%0d want=5", count); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL rr_count got=%0d want=0", count); end
        total++; if (bus.upd_valid_o !== 1'b0) begin bad++; $display("FAIL rr_upd_valid got=%b want=0", bus.upd_valid_o); end
        total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL rr_redirect_valid got=%b want=0", redirect_valid); end
        total++; if (redirect_pc !== 32'h0) begin bad++; $display("FAIL rr_redirect_pc got=%h want=0", redirect_pc); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rr_overflow got=%b want=0", overflow); end
        drive(1'b1, 1'b1, 4'd2, 32'h0000_2000, 1'b1, 1'b1);
        tick();
        idle();
        total++; if (redirect_valid !== 1'b1) begin bad++; $display("FAIL rr_post_redirect got=%b want=1", redirect_valid); end
        total++; if (redirect_pc !== 32'h0000_2000) begin bad++; $display("FAIL rr_post_pc got=%h want=00002000", redirect_pc); end
        total++; if (count !== 4'd1) begin bad++; $display("FAIL rr_post_count got=%0d want=1", count); end
    endtask

    initial begin
        clk          = 1'b0;
        reset        = 1'b1;
        recover_done = 1'b0;
        bus.upd_ready_i = 1'b0;
        total        = 0;
        bad          = 0;
        idle();
        test_reset();
        test_basic_fifo();
        test_overflow();
        test_full_passthrough();
        test_back_to_back();
        test_mispredict();
        test_reset_in_recover();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
